// File: rtl/iob_arbiter2.sv
// Two-requester round-robin arbiter in front of a single shared iob target.
// It keeps at most one target transaction outstanding and bounds every read wait with a timeout.
`timescale 1ns/1ps
module iob_arbiter2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TO_W   = 8
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                m0_valid_i,
  input  logic [ADDR_W-1:0]   m0_address_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_ready_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_valid_i,
  input  logic [ADDR_W-1:0]   m1_address_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_ready_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_valid_o,
  output logic [ADDR_W-1:0]   s_address_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic                s_ready_i,
  input  logic                s_rvalid_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  output logic                timeout_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                lst_q, lst_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;

  logic                sel_valid;
  logic [ADDR_W-1:0]   sel_address;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wstrb;
  logic                in_grant, in_wait;
  logic                cnt_max, to_hit;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                grant_ready;

  always_comb begin
    sel_valid   = gnt_q ? m1_valid_i   : m0_valid_i;
    sel_address = gnt_q ? m1_address_i : m0_address_i;
    sel_wdata   = gnt_q ? m1_wdata_i   : m0_wdata_i;
    sel_wstrb   = gnt_q ? m1_wstrb_i   : m0_wstrb_i;
    in_grant    = (state_q == GRANT);
    in_wait     = (state_q == WAIT_RD);
    cnt_max     = &cnt_q;
    // Timeout is qualified by cke_i so a frozen block never repeats the pulse.
    to_hit      = in_wait && cke_i && !s_rvalid_i && cnt_max;
    rsp_valid   = in_wait && (s_rvalid_i || to_hit);
    rsp_data    = (in_wait && !to_hit) ? s_rdata_i : '0;
    grant_ready = in_grant && s_ready_i;

    s_valid_o   = in_grant && sel_valid;
    s_address_o = in_grant ? sel_address : '0;
    s_wdata_o   = in_grant ? sel_wdata   : '0;
    s_wstrb_o   = in_grant ? sel_wstrb   : '0;

    m0_ready_o  = grant_ready && !gnt_q;
    m1_ready_o  = grant_ready &&  gnt_q;
    m0_rvalid_o = rsp_valid   && !gnt_q;
    m1_rvalid_o = rsp_valid   &&  gnt_q;
    m0_rdata_o  = gnt_q ? '0 : rsp_data;
    m1_rdata_o  = gnt_q ? rsp_data : '0;
    timeout_o   = to_hit;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    lst_d   = lst_q;
    cnt_d   = cnt_q;
    if (cke_i) begin
      case (state_q)
        IDLE: begin
          if (m0_valid_i || m1_valid_i) begin
            gnt_d   = (m0_valid_i && m1_valid_i) ? !lst_q : m1_valid_i;
            state_d = GRANT;
          end
        end
        GRANT: begin
          // A withdrawn request does not count as service, so lst is left alone.
          if (!sel_valid) begin
            state_d = IDLE;
          end else if (s_ready_i) begin
            if (|sel_wstrb) begin
              lst_d   = gnt_q;
              state_d = IDLE;
            end else begin
              cnt_d   = '0;
              state_d = WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (s_rvalid_i || cnt_max) begin
            lst_d   = gnt_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      lst_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      lst_q   <= lst_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_iob_arbiter2.sv
// Self-checking bench for iob_arbiter2: directed scenarios plus a randomized run
// against a transaction-level model of two requesters and one target.
`timescale 1ns/1ps
module tb_iob_arbiter2;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int SW       = DW / 8;
  localparam int TW       = 4;
  localparam int TO_LIMIT = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          cke;
  logic          m0_valid, m1_valid;
  logic [AW-1:0] m0_address, m1_address;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [SW-1:0] m0_wstrb, m1_wstrb;
  logic          m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_valid, s_ready, s_rvalid, timeout;
  logic [AW-1:0] s_address;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic [1+AW+DW+SW+3*(2+DW)-1:0] all_outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign all_outs = {s_valid, s_address, s_wdata, s_wstrb, m0_ready, m0_rvalid, m0_rdata,
                     m1_ready, m1_rvalid, m1_rdata, timeout};

  iob_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .TO_W(TW)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .m0_valid_i(m0_valid), .m0_address_i(m0_address), .m0_wdata_i(m0_wdata),
    .m0_wstrb_i(m0_wstrb), .m0_ready_o(m0_ready), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_valid_i(m1_valid), .m1_address_i(m1_address), .m1_wdata_i(m1_wdata),
    .m1_wstrb_i(m1_wstrb), .m1_ready_o(m1_ready), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .s_valid_o(s_valid), .s_address_o(s_address), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_ready_i(s_ready), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .timeout_o(timeout)
  );

  task automatic idle_inputs();
    cke = 1'b1;
    m0_valid = 1'b0; m0_address = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_address = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    arst_n = 1'b0;
    m0_valid = 1'b1; m1_valid = 1'b1; m0_wstrb = '1; m0_address = 32'hFFFF_0000;
    s_ready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (all_outs !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got %h expected 0", all_outs);
      end
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (all_outs !== '0) begin
        errors++;
        $display("[TB] FAIL post_reset_outputs: got %h expected 0", all_outs);
      end
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_single_write();
    do_reset();
    m0_valid = 1'b1; m0_address = 32'h10; m0_wdata = 32'hA5A5_A5A5; m0_wstrb = 4'hF; s_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_valid, m0_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL wr_cycle1: got %b expected 00", {s_valid, m0_ready});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({s_valid, m0_ready, m1_ready} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL wr_cycle2_hs: got %b expected 110", {s_valid, m0_ready, m1_ready});
    end
    checks++;
    if ({s_address, s_wdata, s_wstrb} !== {32'h10, 32'hA5A5_A5A5, 4'hF}) begin
      errors++;
      $display("[TB] FAIL wr_cycle2_req: got %h expected %h", {s_address, s_wdata, s_wstrb},
               {32'h10, 32'hA5A5_A5A5, 4'hF});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({s_valid, m0_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL wr_cycle3_idle: got %b expected 00", {s_valid, m0_ready});
    end
    next_cycle();
    m0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_withdrawn: got %b expected 0", s_valid);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    m1_valid = 1'b1; m1_address = 32'h20; m1_wdata = $urandom(); m1_wstrb = '0; s_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_cycle1: got %b expected 0", s_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({s_valid, m1_ready, m0_ready, s_address, s_wstrb} !== {3'b110, 32'h20, 4'h0}) begin
      errors++;
      $display("[TB] FAIL rd_cycle2: got %h expected %h", {s_valid, m1_ready, m0_ready, s_address, s_wstrb},
               {3'b110, 32'h20, 4'h0});
    end
    next_cycle();
    m1_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({m1_rvalid, m0_rvalid, s_valid} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL rd_wait: got %b expected 000", {m1_rvalid, m0_rvalid, s_valid});
      end
      next_cycle();
    end
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m1_rdata} !== {1'b1, 32'h1234_5678}) begin
      errors++;
      $display("[TB] FAIL rd_data: got %h expected %h", {m1_rvalid, m1_rdata}, {1'b1, 32'h1234_5678});
    end
    checks++;
    if ({m0_ready, m0_rvalid, m0_rdata, timeout} !== '0) begin
      errors++;
      $display("[TB] FAIL rd_m0_quiet: got %h expected 0", {m0_ready, m0_rvalid, m0_rdata, timeout});
    end
    next_cycle();
    s_rdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rd_stray_rvalid: got %b expected 00", {m1_rvalid, m0_rvalid});
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_contention();
    logic exp_next;
    logic k;
    int grants;
    exp_next = 1'b0;
    grants = 0;
    do_reset();
    m0_valid = 1'b1; m0_address = 32'h100; m0_wdata = 32'h0000_0A0A; m0_wstrb = 4'hF;
    m1_valid = 1'b1; m1_address = 32'h200; m1_wdata = 32'h0000_0B0B; m1_wstrb = 4'h3;
    s_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && grants < 8; cyc++) begin
      @(negedge clk);
      if (m0_ready && m1_ready) begin
        checks++; errors++;
        $display("[TB] FAIL cont_both_ready: got 11 expected one-hot");
      end else if (m0_ready || m1_ready) begin
        k = m1_ready;
        checks++;
        if (k !== exp_next) begin
          errors++;
          $display("[TB] FAIL cont_order grant %0d: got m%0d expected m%0d", grants, k, exp_next);
        end
        checks++;
        if (s_address !== (k ? 32'h200 : 32'h100)) begin
          errors++;
          $display("[TB] FAIL cont_addr: got %h expected %h", s_address, k ? 32'h200 : 32'h100);
        end
        grants++;
        exp_next = !exp_next;
      end
      next_cycle();
    end
    checks++;
    if (grants != 8) begin
      errors++;
      $display("[TB] FAIL cont_grant_count: got %0d expected 8", grants);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    m0_valid = 1'b1; m0_address = 32'h40; m0_wstrb = '0; s_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({s_valid, m0_ready} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL to_accept: got %b expected 11", {s_valid, m0_ready});
    end
    next_cycle();
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= TO_LIMIT; i++) begin
      @(negedge clk);
      checks++;
      if ({m0_rvalid, timeout} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL to_early wait %0d: got %b expected 00", i, {m0_rvalid, timeout});
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if ({m0_rvalid, timeout, m0_rdata, m1_rvalid} !== {2'b11, 32'h0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL to_fire: got %h expected %h", {m0_rvalid, timeout, m0_rdata, m1_rvalid},
               {2'b11, 32'h0, 1'b0});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({m0_rvalid, timeout} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL to_pulse_width: got %b expected 00", {m0_rvalid, timeout});
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_withdraw_cke();
    do_reset();
    m0_valid = 1'b1; m0_address = 32'h30; m0_wstrb = 4'h1; s_ready = 1'b1;
    next_cycle();
    next_cycle();
    m0_valid = 1'b0; m1_valid = 1'b1; m1_address = 32'h50; m1_wstrb = 4'hF;
    next_cycle();
    m1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wd_no_request: got %b expected 0", s_valid);
    end
    next_cycle();
    m0_valid = 1'b1; m1_valid = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({m1_ready, m0_ready, s_address} !== {2'b10, 32'h50}) begin
      errors++;
      $display("[TB] FAIL wd_lst_kept: got %h expected %h", {m1_ready, m0_ready, s_address}, {2'b10, 32'h50});
    end
    next_cycle();
    m1_valid = 1'b0; m0_wstrb = '0; m0_address = 32'h60;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({m0_ready, s_wstrb} !== {1'b1, 4'h0}) begin
      errors++;
      $display("[TB] FAIL cke_read_accept: got %h expected %h", {m0_ready, s_wstrb}, {1'b1, 4'h0});
    end
    next_cycle();
    m0_valid = 1'b0; s_ready = 1'b0;
    repeat (3) next_cycle();
    cke = 1'b0; m1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({s_valid, m0_rvalid, timeout, m1_ready} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL cke_frozen: got %b expected 0000", {s_valid, m0_rvalid, timeout, m1_ready});
      end
      next_cycle();
    end
    cke = 1'b1;
    for (int i = 4; i <= TO_LIMIT + 1; i++) begin
      @(negedge clk);
      checks++;
      if ({timeout, m0_rvalid} !== ((i == TO_LIMIT + 1) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("[TB] FAIL cke_resume wait %0d: got %b expected %b", i, {timeout, m0_rvalid},
                 (i == TO_LIMIT + 1) ? 2'b11 : 2'b00);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m0_valid = 1'b1; m0_address = 32'h70; m0_wstrb = '0; s_ready = 1'b1;
    next_cycle();
    next_cycle();
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h1111_2222;
    next_cycle();
    next_cycle();
    checks++;
    if (m0_rdata !== 32'h1111_2222) begin
      errors++;
      $display("[TB] FAIL mid_pass_through: got %h expected 11112222", m0_rdata);
    end
    #2;
    arst_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("[TB] FAIL mid_async_reset: got %h expected 0", all_outs);
    end
    @(negedge clk);
    arst_n = 1'b1;
    next_cycle();
    s_rvalid = 1'b1; s_rdata = 32'h8765_4321;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, s_valid} !== '0) begin
        errors++;
        $display("[TB] FAIL mid_late_rvalid: got %h expected 0", {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, s_valid});
      end
      next_cycle();
    end
    s_rvalid = 1'b0;
    m1_valid = 1'b1; m1_address = 32'h80; m1_wstrb = 4'hF; s_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_idle: got %b expected 0", s_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({s_valid, m1_ready} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL mid_new_grant: got %b expected 11", {s_valid, m1_ready});
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_random();
    logic          pend [2];
    logic          waitr [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic [SW-1:0] st [2];
    logic          busy, busy_now, emit, owner, acc, match;
    int            lat, done;
    busy = 1'b0; owner = 1'b0; lat = 0; done = 0;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; waitr[k] = 1'b0; a[k] = '0; d[k] = '0; st[k] = '0;
    end
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      m0_valid = pend[0]; m0_address = a[0]; m0_wdata = d[0]; m0_wstrb = st[0];
      m1_valid = pend[1]; m1_address = a[1]; m1_wdata = d[1]; m1_wstrb = st[1];
      s_ready  = ($urandom_range(0, 3) != 0);
      emit     = busy && (lat == 0);
      s_rvalid = emit ? 1'b1 : (!busy && ($urandom_range(0, 7) == 0));
      s_rdata  = $urandom();
      busy_now = busy;
      @(negedge clk);
      checks++;
      if (m0_ready && m1_ready) begin
        errors++;
        $display("[TB] FAIL rnd_both_ready cycle %0d: got 11 expected one-hot", cyc);
      end
      checks++;
      if ({m0_rvalid, m1_rvalid} !== {emit && !owner, emit && owner}) begin
        errors++;
        $display("[TB] FAIL rnd_rvalid cycle %0d: got %b expected %b", cyc, {m0_rvalid, m1_rvalid},
                 {emit && !owner, emit && owner});
      end
      if (emit) begin
        checks++;
        if ((owner ? m1_rdata : m0_rdata) !== s_rdata) begin
          errors++;
          $display("[TB] FAIL rnd_rdata cycle %0d: got %h expected %h", cyc, owner ? m1_rdata : m0_rdata, s_rdata);
        end
      end
      checks++;
      if (timeout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rnd_timeout cycle %0d: got 1 expected 0", cyc);
      end
      if (s_valid) begin
        match = (pend[0] && {s_address, s_wdata, s_wstrb} == {a[0], d[0], st[0]}) ||
                (pend[1] && {s_address, s_wdata, s_wstrb} == {a[1], d[1], st[1]});
        checks++;
        if (busy_now || !match) begin
          errors++;
          $display("[TB] FAIL rnd_request cycle %0d: got busy=%b match=%b expected busy=0 match=1", cyc, busy_now, match);
        end
      end
      if (emit) begin
        busy = 1'b0;
        waitr[owner] = 1'b0;
        done++;
      end else if (busy && lat > 0) begin
        lat--;
      end
      for (int k = 0; k < 2; k++) begin
        acc = pend[k] && ((k == 1) ? m1_ready : m0_ready);
        if (acc) begin
          checks++;
          if (busy_now || !(s_valid && s_ready && {s_address, s_wdata, s_wstrb} == {a[k], d[k], st[k]})) begin
            errors++;
            $display("[TB] FAIL rnd_accept m%0d cycle %0d: got s_valid=%b addr=%h expected 1 addr=%h",
                     k, cyc, s_valid, s_address, a[k]);
          end
          pend[k] = 1'b0;
          if (st[k] == '0) begin
            busy = 1'b1; owner = (k == 1); lat = $urandom_range(0, 6); waitr[k] = 1'b1;
          end else begin
            done++;
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && !waitr[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          a[k] = $urandom();
          d[k] = $urandom();
          st[k] = ($urandom_range(0, 1) == 1) ? SW'($urandom()) : '0;
        end
      end
      next_cycle();
    end
    checks++;
    if (done < 20) begin
      errors++;
      $display("[TB] FAIL rnd_progress: got %0d expected at least 20", done);
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_timeout();
    test_withdraw_cke();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_arbiter2.md
IOB_ARBITER2 -- requirements
Module: iob_arbiter2

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be, one per line:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TO_W, 8, read-timeout counter width
REQ-003 Ports SHALL be, one per line:
- clk_i  in  1  clock, rising edge
- arst_n_i  in  1  asynchronous active-low reset
- cke_i  in  1  clock enable; 0 freezes all state
- mK_valid_i  in  1  request valid, requester K (K=0,1)
- mK_address_i  in  ADDR_W  request address
- mK_wdata_i  in  DATA_W  write data
- mK_wstrb_i  in  DATA_W/8  byte strobes; all-zero means read
- mK_ready_o  out  1  request accepted
- mK_rvalid_o  out  1  read data valid
- mK_rdata_o  out  DATA_W  read data
- s_valid_o  out  1  request to shared target
- s_address_o  out  ADDR_W  address to target
- s_wdata_o  out  DATA_W  write data to target
- s_wstrb_o  out  DATA_W/8  strobes to target
- s_ready_i  in  1  target accepts request
- s_rvalid_i  in  1  target read data valid
- s_rdata_i  in  DATA_W  target read data
- timeout_o  out  1  one-cycle pulse on read timeout

Function
REQ-004 The FSM SHALL have states IDLE, GRANT and WAIT_RD, plus a grant register gnt (0/1) and a last-served register lst.
REQ-005 IDLE: if only one mK_valid_i is high, gnt SHALL load K; if both are high, gnt SHALL load ~lst; the next state SHALL be GRANT; with no request the state SHALL remain IDLE.
REQ-006 GRANT: s_valid_o, s_address_o, s_wdata_o and s_wstrb_o SHALL be the granted requester's inputs (combinational mux); mgnt_ready_o SHALL equal s_ready_i; the other requester's ready SHALL be 0.
REQ-007 GRANT with s_valid_o && s_ready_i and nonzero wstrb (write) SHALL set lst<=gnt and go to IDLE.
REQ-008 GRANT with s_valid_o && s_ready_i and zero wstrb (read) SHALL go to WAIT_RD and clear the timeout counter.
REQ-009 GRANT with the granted requester's valid low SHALL return to IDLE without updating lst; no target request is issued.
REQ-010 WAIT_RD: s_valid_o SHALL be 0; mgnt_rvalid_o SHALL equal s_rvalid_i; on s_rvalid_i, lst<=gnt and the next state SHALL be IDLE.
REQ-011 mK_rdata_o SHALL equal s_rdata_i for the granted requester and 0 otherwise; mK_rvalid_o SHALL be 0 outside WAIT_RD.
REQ-012 s_rvalid_i SHALL be ignored in IDLE and GRANT.
REQ-013 In WAIT_RD, the TO_W-bit counter SHALL increment each enabled cycle without s_rvalid_i; on reaching 2^TO_W-1 without s_rvalid_i, the block SHALL drive mgnt_rvalid_o=1 and mgnt_rdata_o=0, pulse timeout_o for one cycle, set lst<=gnt, and go to IDLE.
REQ-014 If s_rvalid_i and the timeout condition occur in the same cycle, s_rvalid_i SHALL win: real data is returned and timeout_o stays 0.
REQ-015 With cke_i=0, state, gnt, lst and the counter SHALL hold; combinational outputs SHALL follow the held state.
REQ-016 At most one target transaction SHALL be outstanding at any time.
REQ-017 Minimum write latency SHALL be 2 cycles from mK_valid_i high to mK_ready_o high (IDLE + GRANT) when the target is always ready.

Reset
REQ-018 arst_n_i=0 SHALL force state=IDLE, gnt=0, lst=1, counter=0 immediately, regardless of clk_i or cke_i.
REQ-019 During and after reset, all outputs SHALL be 0 until the first grant.
REQ-020 Reset mid-transaction SHALL abandon the transaction: no rvalid or ready is delivered for it, and s_rvalid_i arriving after reset release SHALL be ignored per REQ-012.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single write: m0 write addr 0x10, data 0xA5A5A5A5, wstrb 0xF, target always ready -> s_valid_o high in cycle 2, m0_ready_o=1 in cycle 2, state back to IDLE in cycle 3.
- Single read: m1 read addr 0x20, target ready then rvalid 3 cycles later with 0x12345678 -> m1_rvalid_o=1 with m1_rdata_o=0x12345678; m0 outputs stay 0.
- Contention: both requesters issue writes continuously after reset -> grants alternate m0, m1, m0, m1 (lst reset=1, so m0 is served first).
- Timeout: m0 read, target never asserts rvalid, TO_W=4 -> after 15 WAIT_RD cycles, m0_rvalid_o=1, m0_rdata_o=0, one-cycle timeout_o pulse.
- Withdraw plus cke: m1 granted, then drops valid in GRANT -> IDLE, lst unchanged, no s_valid_o; holding cke_i=0 for 5 cycles in WAIT_RD -> counter and state frozen.
- Reset mid-read: arst_n_i low in WAIT_RD, late s_rvalid_i after release -> no mK_rvalid_o, state IDLE.
